// File: rtl/baccarat_datapath.sv
// Baccarat hand-holding datapath: six card slots, hand scores, load-protocol checking and a round tally.
// Define BACCARAT_DATAPATH_LFSR_EN to draw cards from an 8-bit LFSR instead of the 1..13 wrap counter.
module baccarat_datapath #(
  parameter int TALLY_W = 8
) (
  input  logic               slow_clock,
  input  logic               resetb,
  input  logic               round_start,
  input  logic               load_pcard1,
  input  logic               load_pcard2,
  input  logic               load_pcard3,
  input  logic               load_dcard1,
  input  logic               load_dcard2,
  input  logic               load_dcard3,
  input  logic               player_win_light,
  input  logic               dealer_win_light,
  output logic [3:0]         pcard1,
  output logic [3:0]         pcard2,
  output logic [3:0]         pcard3,
  output logic [3:0]         dcard1,
  output logic [3:0]         dcard2,
  output logic [3:0]         dcard3,
  output logic [3:0]         pscore,
  output logic [3:0]         dscore,
  output logic [3:0]         next_card,
  output logic               protocol_err,
  output logic [TALLY_W-1:0] player_wins,
  output logic [TALLY_W-1:0] dealer_wins,
  output logic [TALLY_W-1:0] ties
);

  logic [5:0][3:0]    slot_q, slot_d;
  logic [5:0]         loads;
  logic [2:0]         ld_cnt;
  logic               err_q, err_d;
  logic               seen_q, seen_d;
  logic [TALLY_W-1:0] pw_q, pw_d, dw_q, dw_d, ties_q, ties_d;

  function automatic logic [3:0] card_val(input logic [3:0] c);
    return (c <= 4'd9) ? c : 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] s;
    s = {1'b0, card_val(a)} + {1'b0, card_val(b)} + {1'b0, card_val(c)};
    if (s >= 5'd20)      s = s - 5'd20;
    else if (s >= 5'd10) s = s - 5'd10;
    return s[3:0];
  endfunction

  function automatic logic [TALLY_W-1:0] sat_inc(input logic [TALLY_W-1:0] c);
    return (&c) ? c : c + TALLY_W'(1);
  endfunction

`ifdef BACCARAT_DATAPATH_LFSR_EN
  logic [7:0] lfsr_q;

  // Taps 8,6,5,4 (bits 7,5,4,3); a nonzero seed keeps it off the all-zero lockup state.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) lfsr_q <= 8'hA5;
    else         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign next_card = 4'(lfsr_q % 8'd13) + 4'd1;
`else
  logic [3:0] cnt_q;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)              cnt_q <= 4'd1;
    else if (cnt_q >= 4'd13)  cnt_q <= 4'd1;
    else                      cnt_q <= cnt_q + 4'd1;
  end

  assign next_card = cnt_q;
`endif

  assign loads = {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1};

  always_comb begin
    slot_d = slot_q;
    err_d  = err_q;
    seen_d = seen_q;
    pw_d   = pw_q;
    dw_d   = dw_q;
    ties_d = ties_q;
    ld_cnt = '0;
    for (int i = 0; i < 6; i++) ld_cnt = ld_cnt + {2'b00, loads[i]};

    if (round_start) begin
      slot_d = '0;
      err_d  = 1'b0;
      seen_d = 1'b0;
    end else begin
      if (ld_cnt > 3'd1) begin
        err_d = 1'b1;
      end else if (ld_cnt == 3'd1) begin
        for (int i = 0; i < 6; i++) begin
          if (loads[i]) begin
            if (slot_q[i] != 4'd0) err_d = 1'b1;
            else                   slot_d[i] = next_card;
          end
        end
      end
      // Only the first cycle of a lit result counts; result_seen blocks repeats until round_start.
      if ((player_win_light || dealer_win_light) && !seen_q) begin
        seen_d = 1'b1;
        if (player_win_light && dealer_win_light) ties_d = sat_inc(ties_q);
        else if (player_win_light)                pw_d   = sat_inc(pw_q);
        else                                      dw_d   = sat_inc(dw_q);
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      slot_q <= '0;
      err_q  <= 1'b0;
      seen_q <= 1'b0;
      pw_q   <= '0;
      dw_q   <= '0;
      ties_q <= '0;
    end else begin
      slot_q <= slot_d;
      err_q  <= err_d;
      seen_q <= seen_d;
      pw_q   <= pw_d;
      dw_q   <= dw_d;
      ties_q <= ties_d;
    end
  end

  assign pcard1       = slot_q[0];
  assign pcard2       = slot_q[1];
  assign pcard3       = slot_q[2];
  assign dcard1       = slot_q[3];
  assign dcard2       = slot_q[4];
  assign dcard3       = slot_q[5];
  assign pscore       = hand_score(slot_q[0], slot_q[1], slot_q[2]);
  assign dscore       = hand_score(slot_q[3], slot_q[4], slot_q[5]);
  assign protocol_err = err_q;
  assign player_wins  = pw_q;
  assign dealer_wins  = dw_q;
  assign ties         = ties_q;

endmodule

// File: doc/baccarat_datapath.md
# baccarat_datapath

Card-holding datapath answering the Baccarat round controller's load strobes. Each `load_*` strobe captures the current card from an internal card source into one of six hand slots. The block returns `pscore`, `dscore` and `pcard3` to the controller, and keeps a running win/loss/tie tally from the controller's win lights. It sits between the card source and the round controller, and drives the card/score displays.

## Interface
- `TALLY_W`, default 8: width of each tally counter; counters saturate at 2^TALLY_W−1.

Ports:
- `slow_clock` in 1: sole clock; all state changes on its rising edge.
- `resetb` in 1: reset, asynchronous, active-low.
- `round_start` in 1: synchronous; clears the hand for a new round.
- `load_pcard1`, `load_pcard2`, `load_pcard3` in 1 each: player slot load strobes.
- `load_dcard1`, `load_dcard2`, `load_dcard3` in 1 each: dealer slot load strobes.
- `player_win_light`, `dealer_win_light` in 1 each: round result from the controller.
- `pcard1`, `pcard2`, `pcard3` out 4 each: player slots. 0 = empty, 1..13 = A..K.
- `dcard1`, `dcard2`, `dcard3` out 4 each: dealer slots, same encoding.
- `pscore`, `dscore` out 4 each: hand scores, 0..9.
- `next_card` out 4: card that a load at the next rising edge would capture, 1..13.
- `protocol_err` out 1: sticky load-protocol violation flag.
- `player_wins`, `dealer_wins`, `ties` out `TALLY_W` each: round tallies.

## Operation
- **Card value:** 1..9 map to their face value; 10..13 and empty map to 0.
  - `pscore` = (val(pcard1) + val(pcard2) + val(pcard3)) mod 10. `dscore` is computed the same way from the dealer slots.
  - Scores are combinational from the slot registers; the sum is at most 27 and needs 5 bits internally.
- **Card source:** advances every cycle; `next_card` is its value. Without the macro it is a counter: reset value 1, +1 per cycle, wraps 13→1.
- **Load, valid case:** exactly one `load_*` is high and its slot is 0. The slot captures `next_card` at the edge.
- **Load, violations:** each sets `protocol_err` and leaves all slots unchanged.
  - Two or more `load_*` high in the same cycle.
  - A load targets a nonzero slot; that slot is not overwritten.
- **`round_start`:**
  - Clears all six slots, `protocol_err` and the internal `result_seen` flag.
  - Has priority over any load or win light in the same cycle: that load is ignored and nothing is counted.
  - Does not touch the tallies or the card source.
- **Tally:** counts once per round, in the first cycle where (`player_win_light` | `dealer_win_light`) is high and `result_seen` is 0. In that cycle `result_seen` is set to 1 and:
  - player light only → `player_wins` +1;
  - dealer light only → `dealer_wins` +1;
  - both lights → `ties` +1.
- Lights that stay high in later cycles do not count again until `round_start`. Counters saturate and never wrap.
- **Reset values (`resetb` low, immediate):**
  - All slots 0, so `pscore` = `dscore` = 0.
  - `protocol_err` 0, `result_seen` 0, all tallies 0.
  - Card source at its seed; `next_card` = 1 without the macro.
- Reset mid-round discards the hand and tallies immediately. Loads during reset are ignored.

## Timing
- Load latency is one edge: a slot and its score update at the edge that samples the strobe, and are visible after that edge.
- `protocol_err` and tally increments appear after the offending or result edge.
- `next_card` changes every edge. The value captured is the one visible before the edge.
- `resetb` deassertion is taken as synchronous to `slow_clock`. The first source advance occurs at the first edge with `resetb` high.

## Configuration
- **`BACCARAT_DATAPATH_LFSR_EN` defined:** the card source is an 8-bit Fibonacci LFSR.
  - Taps 8,6,5,4, shift left, feedback into bit 0; seed 8'hA5 on reset; shifts every cycle.
  - `next_card` = (lfsr mod 13) + 1.
  - The LFSR never reaches 0.
- **Not defined:** the 1..13 wrap counter above.
- All other behaviour is identical in both builds.

## Test plan
- Counter build: reset, release, pulse `load_pcard1` at the first edge, then `load_dcard1`, `load_pcard2`, `load_dcard2` on the next three edges → `pcard1`=1, `dcard1`=2, `pcard2`=3, `dcard2`=4, `pscore`=4, `dscore`=6, `protocol_err`=0.
- Score wrap: with `pcard1`=7 and `pcard2`=8 in place, load `pcard3` when `next_card`=12 → `pscore`=5 (15 mod 10; Q counts 0), `pcard3`=12.
- Violations:
  - `load_pcard1` and `load_dcard1` high together → no slot changes, `protocol_err`=1.
  - Then `round_start` → all slots 0, `protocol_err`=0.
  - Reloading a filled `pcard1` → value unchanged, `protocol_err`=1.
- Tally:
  - Hold `player_win_light` high for 5 cycles → `player_wins`=1 exactly.
  - `round_start`, then both lights high → `ties`=1.
  - `round_start` coincident with `dealer_win_light` → `dealer_wins` unchanged.
- Saturation: `TALLY_W`=2, complete 5 player-win rounds → `player_wins`=3.
- Async reset: assert `resetb` low mid-clock with slots loaded → all outputs at reset values before the next edge. LFSR build: `next_card` = (8'hA5 mod 13)+1 = 10 after reset.
